// File: rtl/sys_vga_pkg.sv
// rtl/sys_vga_pkg.sv - shared VGA 640x480@60 timing constants and frame-buffer geometry
package sys_vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int FB_W           = 160;
  localparam int FB_H           = 120;
  localparam int WORDS_PER_LINE = 10;
  localparam int BPP            = 2;
  localparam int SCALE_SHIFT    = 2;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  // Word offset of a frame-buffer line: y*WORDS_PER_LINE built from shifts (10 = 8 + 2).
  function automatic logic [10:0] line_word(input logic [6:0] y);
    return ({4'd0, y} << 3) + ({4'd0, y} << 1);
  endfunction

endpackage

// File: rtl/sys_vga_timing.sv
// rtl/sys_vga_timing.sv - horizontal/vertical counters and stage-0 sync/visible decode
module sys_vga_timing
  import sys_vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] pix_x_o,
  output logic [6:0] pix_y_o,
  output sync_t      sync_o,
  output logic       frame_end_o
);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       h_last, v_last;

  always_comb begin
    h_last = (hcnt_q == 10'(H_TOT - 1));
    v_last = (vcnt_q == 10'(V_TOT - 1));
    hcnt_d = h_last ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    sync_o.vis = (hcnt_q < 10'(H_VIS)) && (vcnt_q < 10'(V_VIS));
    sync_o.hs  = !((hcnt_q >= 10'(H_VIS + H_FP)) && (hcnt_q < 10'(H_VIS + H_FP + H_SYNC)));
    sync_o.vs  = !((vcnt_q >= 10'(V_VIS + V_FP)) && (vcnt_q < 10'(V_VIS + V_FP + V_SYNC)));
    sync_o.fs  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  assign frame_end_o = h_last && v_last;
  assign pix_x_o     = 8'(hcnt_q >> SCALE_SHIFT);
  assign pix_y_o     = 7'(vcnt_q >> SCALE_SHIFT);

endmodule

// File: rtl/sys_vga_scanout.sv
// rtl/sys_vga_scanout.sv - frame-buffer fetch, 2-stage pixel/sync pipeline and palette to VGA pins
module sys_vga_scanout
  import sys_vga_pkg::*;
#(
  parameter logic [10:0] FB_BASE = 11'd0,
  parameter logic [23:0] PAL0    = 24'h000000,
  parameter logic [23:0] PAL1    = 24'hFF0000,
  parameter logic [23:0] PAL2    = 24'h00FF00,
  parameter logic [23:0] PAL3    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [10:0] address2,
  output logic        chipselect2,
  output logic        write2,
  input  logic [31:0] readdata2,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);

  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  sync_t       s0;
  logic        frame_end;

  sys_vga_timing u_timing (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .pix_x_o     (pix_x),
    .pix_y_o     (pix_y),
    .sync_o      (s0),
    .frame_end_o (frame_end)
  );

  logic [10:0] addr_calc;
  logic [10:0] addr_hold_q;
  logic        en_q;
  logic [3:0]  sel_q;
  sync_t       s1_q;
  logic [1:0]  code;
  logic [23:0] rgb_d, rgb_q;
  logic        hs_q, vs_q, blank_q, fs_q;

  // Counters sit at (0,0) during reset, so the reset-time address is FB_BASE without extra muxing.
  assign addr_calc   = FB_BASE + line_word(pix_y) + {7'd0, pix_x[7:4]};
  assign address2    = s0.vis ? addr_calc : addr_hold_q;
  assign chipselect2 = s0.vis && reset_n;
  assign write2      = 1'b0;

  assign code = readdata2[{sel_q, 1'b0} +: 2];

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_q.vis && en_q) begin
      case (code)
        2'd0:    rgb_d = PAL0;
        2'd1:    rgb_d = PAL1;
        2'd2:    rgb_d = PAL2;
        default: rgb_d = PAL3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hold_q <= FB_BASE;
      en_q        <= 1'b0;
      sel_q       <= 4'd0;
      s1_q        <= SYNC_IDLE;
      rgb_q       <= 24'h000000;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      if (s0.vis) begin
        addr_hold_q <= addr_calc;
      end
      // Enable only changes between frames so a frame is never partially blanked.
      if (frame_end) begin
        en_q <= enable;
      end
      sel_q   <= pix_x[3:0];
      s1_q    <= s0;
      rgb_q   <= rgb_d;
      hs_q    <= s1_q.hs;
      vs_q    <= s1_q.vs;
      blank_q <= s1_q.vis;
      fs_q    <= s1_q.fs;
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sys_vga_scanout.sv
// tb/tb_sys_vga_scanout.sv - self-checking bench for sys_vga_scanout
module tb_sys_vga_scanout;

  localparam int HT = 800;
  localparam int VT = 525;
  localparam int FT = HT * VT;
  localparam int FBB = 0;
  localparam logic [23:0] C0 = 24'h000000;
  localparam logic [23:0] C1 = 24'hFF0000;
  localparam logic [23:0] C2 = 24'h00FF00;
  localparam logic [23:0] C3 = 24'hFFFFFF;

  localparam int K_F1RGB = 0, K_F2RGB = 1, K_F2BLK = 2, K_A4 = 3, K_CS4 = 4, K_A479 = 5, K_CS479 = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] address2;
  logic        chipselect2, write2;
  logic [31:0] readdata2;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  int checks = 0;
  int errors = 0;

  sys_vga_scanout dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .address2    (address2),
    .chipselect2 (chipselect2),
    .write2      (write2),
    .readdata2   (readdata2),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) readdata2 <= mem[address2];

  // Clock edges since the last reset release: the display position is k modulo one frame.
  int k;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic [23:0] cap_f1  [0:63];
  logic [23:0] cap_f2  [0:63];
  logic        cap_b2  [0:63];
  logic [10:0] cap_a4  [0:799];
  logic        cap_cs4 [0:799];
  logic [10:0] cap_a479[0:799];
  logic        cap_cs479[0:799];

  bit   en_frame[0:3];
  int   hold_m = FBB;
  int   line_err = 0;
  int   mon_cnt = 0;
  bit   mon_on = 1'b1;
  bit   prev_vs = 1'b1;
  int   vs_falls[$];
  string det_what;
  int   det_k, det_act, det_exp;

  function automatic logic [23:0] pal(int c);
    case (c)
      0: return C0;
      1: return C1;
      2: return C2;
      default: return C3;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(int h, int v, bit en);
    int px, py, c;
    logic [31:0] w;
    if (!(h < 640 && v < 480) || !en) return 24'h0;
    px = h / 4;
    py = v / 4;
    w  = mem[FBB + py * 10 + px / 16];
    c  = int'((w >> (2 * (px % 16))) & 32'd3);
    return pal(c);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic flush();
    checks++;
    if (line_err != 0) begin
      errors++;
      $display("FAIL scan_line k=%0d bad_cycles=%0d first=%s actual=%0h required=%0h",
               det_k, line_err, det_what, det_act, det_exp);
    end
    line_err = 0;
    mon_cnt  = 0;
  endtask

  task automatic note(string what, int act, int exp);
    if (line_err == 0) begin
      det_what = what; det_k = k; det_act = act; det_exp = exp;
    end
    line_err++;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      if (mon_cnt > 0) flush();
      hold_m  = FBB;
      prev_vs = 1'b1;
      vs_falls.delete();
      for (int i = 0; i < 4; i++) en_frame[i] = 1'b0;
    end else if (mon_on) begin
      int p, f, h0, v0, e_addr, kk, po, fo, ho, vo;
      bit vis0, ehs, evs, eblk, efs;
      logic [23:0] ergb;
      p  = k % FT; f = k / FT; h0 = p % HT; v0 = p / HT;
      vis0 = (h0 < 640) && (v0 < 480);
      e_addr = vis0 ? FBB + (v0 / 4) * 10 + (h0 / 4) / 16 : hold_m;
      if (vis0) hold_m = e_addr;
      if (int'(address2) != e_addr) note("address2", int'(address2), e_addr);
      if (chipselect2 !== vis0)     note("chipselect2", int'(chipselect2), int'(vis0));
      if (write2 !== 1'b0)          note("write2", int'(write2), 0);
      if (p == FT - 1 && f < 3) en_frame[f + 1] = enable;
      if (v0 == 4)   begin cap_a4[h0]   = address2; cap_cs4[h0]   = chipselect2; end
      if (v0 == 479) begin cap_a479[h0] = address2; cap_cs479[h0] = chipselect2; end

      if (k < 2) begin
        ehs = 1; evs = 1; eblk = 0; efs = 0; ergb = 24'h0;
        fo = 0; ho = 0; vo = 0;
      end else begin
        kk = k - 2; po = kk % FT; fo = kk / FT; ho = po % HT; vo = po / HT;
        ehs  = !(ho >= 656 && ho < 752);
        evs  = !(vo >= 490 && vo < 492);
        eblk = (ho < 640) && (vo < 480);
        efs  = (ho == 0) && (vo == 0);
        ergb = exp_rgb(ho, vo, en_frame[fo]);
        if (fo == 1 && vo == 0 && ho < 64) cap_f1[ho] = {vga_r, vga_g, vga_b};
        if (fo == 2 && vo == 0 && ho < 64) begin
          cap_f2[ho] = {vga_r, vga_g, vga_b};
          cap_b2[ho] = vga_blank_n;
        end
      end
      if (vga_hs !== ehs)             note("vga_hs", int'(vga_hs), int'(ehs));
      if (vga_vs !== evs)             note("vga_vs", int'(vga_vs), int'(evs));
      if (vga_blank_n !== eblk)       note("vga_blank_n", int'(vga_blank_n), int'(eblk));
      if (frame_start !== efs)        note("frame_start", int'(frame_start), int'(efs));
      if ({vga_r, vga_g, vga_b} !== ergb) note("rgb", int'({vga_r, vga_g, vga_b}), int'(ergb));
      if (prev_vs && vga_vs === 1'b0) vs_falls.push_back(k);
      prev_vs = (vga_vs !== 1'b0);
      mon_cnt++;
      if (mon_cnt == HT) flush();
    end
  end

  task automatic check_reset(string nm);
    chk({nm, "_hs"}, 32'(vga_hs), 32'd1);
    chk({nm, "_vs"}, 32'(vga_vs), 32'd1);
    chk({nm, "_blank_n"}, 32'(vga_blank_n), 32'd0);
    chk({nm, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({nm, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({nm, "_cs2"}, 32'(chipselect2), 32'd0);
    chk({nm, "_addr2"}, 32'(address2), 32'(FBB));
    chk({nm, "_write2"}, 32'(write2), 32'd0);
  endtask

  task automatic fs_latency(string nm);
    int got = 0;
    for (int n = 1; n <= 6 && got == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_start === 1'b1) got = n;
    end
    chk(nm, 32'(got), 32'd2);
  endtask

  task automatic wait_k(int target);
    int n = 0;
    while (k < target && n < 2 * FT) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wait_bound", 32'(k), 32'(target));
  endtask

  task automatic measure(string nm, bit use_hs, int exp_active, int exp_period);
    int n = 0, act = 0, per = 0;
    logic s;
    s = use_hs ? !vga_hs : vga_blank_n;
    while (s !== 1'b0 && n < 2000) begin @(negedge clk); n++; s = use_hs ? !vga_hs : vga_blank_n; end
    while (s !== 1'b1 && n < 4000) begin @(negedge clk); n++; s = use_hs ? !vga_hs : vga_blank_n; end
    while (s === 1'b1 && act < 2000) begin @(negedge clk); act++; s = use_hs ? !vga_hs : vga_blank_n; end
    per = act;
    while (s !== 1'b1 && per < 2000) begin @(negedge clk); per++; s = use_hs ? !vga_hs : vga_blank_n; end
    chk({nm, "_active"}, 32'(act), 32'(exp_active));
    chk({nm, "_period"}, 32'(per), 32'(exp_period));
  endtask

  initial begin
    vec_t vt[$];
    logic [31:0] act;
    vt.push_back('{"f1_px0",  K_F1RGB, 0,  32'(C0)});
    vt.push_back('{"f1_px3",  K_F1RGB, 3,  32'(C0)});
    vt.push_back('{"f1_px4",  K_F1RGB, 4,  32'(C1)});
    vt.push_back('{"f1_px7",  K_F1RGB, 7,  32'(C1)});
    vt.push_back('{"f1_px8",  K_F1RGB, 8,  32'(C2)});
    vt.push_back('{"f1_px11", K_F1RGB, 11, 32'(C2)});
    vt.push_back('{"f1_px12", K_F1RGB, 12, 32'(C3)});
    vt.push_back('{"f1_px15", K_F1RGB, 15, 32'(C3)});
    vt.push_back('{"f1_px16", K_F1RGB, 16, 32'(C0)});
    vt.push_back('{"f1_px63", K_F1RGB, 63, 32'(C0)});
    vt.push_back('{"f2_px4",  K_F2RGB, 4,  32'd0});
    vt.push_back('{"f2_px12", K_F2RGB, 12, 32'd0});
    vt.push_back('{"f2_blk0", K_F2BLK, 0,  32'd1});
    vt.push_back('{"f2_blk63",K_F2BLK, 63, 32'd1});
    vt.push_back('{"a4_h0",   K_A4,    0,   32'd10});
    vt.push_back('{"a4_h63",  K_A4,    63,  32'd10});
    vt.push_back('{"a4_h64",  K_A4,    64,  32'd11});
    vt.push_back('{"a4_h639", K_A4,    639, 32'd19});
    vt.push_back('{"a4_h700", K_A4,    700, 32'd19});
    vt.push_back('{"cs4_h0",  K_CS4,   0,   32'd1});
    vt.push_back('{"cs4_h639",K_CS4,   639, 32'd1});
    vt.push_back('{"cs4_h640",K_CS4,   640, 32'd0});
    vt.push_back('{"a479_h0", K_A479,  0,   32'd1190});
    vt.push_back('{"a479_h320",K_A479, 320, 32'd1195});
    vt.push_back('{"a479_h639",K_A479, 639, 32'd1199});
    vt.push_back('{"a479_h799",K_A479, 799, 32'd1199});
    vt.push_back('{"cs479_h799",K_CS479,799, 32'd0});

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[FBB] = 32'h000000E4;
    for (int i = 0; i < 64; i++) begin cap_f1[i] = 'x; cap_f2[i] = 'x; cap_b2[i] = 1'bx; end
    for (int i = 0; i < 800; i++) begin
      cap_a4[i] = 'x; cap_cs4[i] = 1'bx; cap_a479[i] = 'x; cap_cs479[i] = 1'bx;
    end

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_reset("reset_hold");
    reset_n = 1'b1;
    fs_latency("fs_after_reset");

    wait_k(100 * HT + 300);
    reset_n = 1'b0;
    #1;
    check_reset("reset_async");
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset_mid_hold");
    reset_n = 1'b1;
    fs_latency("fs_after_mid_reset");

    measure("hs_low", 1'b1, 96, 800);
    measure("blank_high", 1'b0, 640, 800);

    while (k < 400 * HT) begin
      repeat ($urandom_range(200, 3000)) @(posedge clk);
      #2;
      enable = 1'($urandom);
    end
    enable = 1'b1;

    wait_k(FT + 200 * HT);
    enable = 1'b0;
    while (k < FT + 500 * HT) begin
      repeat ($urandom_range(200, 3000)) @(posedge clk);
      #2;
      enable = 1'($urandom);
    end
    enable = 1'b0;

    wait_k(2 * FT + 10 * HT);
    @(negedge clk);
    mon_on = 1'b0;
    if (mon_cnt > 0) flush();

    foreach (vt[i]) begin
      case (vt[i].kind)
        K_F1RGB: act = 32'(cap_f1[vt[i].idx]);
        K_F2RGB: act = 32'(cap_f2[vt[i].idx]);
        K_F2BLK: act = 32'(cap_b2[vt[i].idx]);
        K_A4:    act = 32'(cap_a4[vt[i].idx]);
        K_CS4:   act = 32'(cap_cs4[vt[i].idx]);
        K_A479:  act = 32'(cap_a479[vt[i].idx]);
        default: act = 32'(cap_cs479[vt[i].idx]);
      endcase
      chk(vt[i].name, act, vt[i].exp);
    end

    chk("vs_fall_count", 32'(vs_falls.size()), 32'd2);
    if (vs_falls.size() >= 2) chk("vs_period", 32'(vs_falls[1] - vs_falls[0]), 32'(FT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
